reorder_buffer: RTL and testbench

//  In-order retirement buffer directly downstream of the ROB tag allocator.
//  - Dispatch writes an entry at the allocator-issued tag.
//  - Writeback marks the entry complete.
//  - The oldest complete entry retires, at most one per cycle, to the rename/free-list stage.
//  - On a branch mispredict, every entry younger than the branch checkpoint is squashed.

---
 rtl/rob_pkg.sv | 16 +
 rtl/rob_ptr_ctrl.sv | 63 ++++++
 rtl/reorder_buffer.sv | 92 +++++++++
 tb/tb_reorder_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared widths and the per-entry record of the reorder buffer.
package rob_pkg;
    localparam int ROB_WIDTH  = 5;
    localparam int AREG_WIDTH = 5;
    localparam int PREG_WIDTH = 7;
    localparam int ROB_DEPTH  = 2 ** ROB_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  has_dest;
        logic [AREG_WIDTH-1:0] areg;
        logic [PREG_WIDTH-1:0] pd_new;
        logic [PREG_WIDTH-1:0] pd_old;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer, full/empty decode and
// the per-tag squash mask for a mispredict flush.
module rob_ptr_ctrl
    import rob_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 alloc_req,
    input  logic                 commit_valid,
    input  logic                 branch_mispredict,
    input  logic [ROB_WIDTH-1:0] flush_tag,
    output logic [ROB_WIDTH-1:0] head,
    output logic [ROB_WIDTH-1:0] tail,
    output logic                 alloc_accept,
    output logic                 rob_full,
    output logic                 rob_empty,
    output logic [ROB_DEPTH-1:0] squash_mask
);
    logic [ROB_WIDTH-1:0] head_reg, head_next;
    logic [ROB_WIDTH-1:0] tail_reg, tail_next;
    logic [ROB_WIDTH:0]   count_reg, count_next;
    logic                 squash_en;
    logic [ROB_WIDTH-1:0] squash_span;

    assign rob_full     = (count_reg == (ROB_WIDTH+1)'(ROB_DEPTH));
    assign rob_empty    = (count_reg == '0);
    assign alloc_accept = alloc_req && !rob_full && !branch_mispredict;
    assign squash_en    = branch_mispredict && (flush_tag != tail_reg);
    assign squash_span  = tail_reg - flush_tag;
    assign head         = head_reg;
    assign tail         = tail_reg;

    // A tag is squashed when its distance from flush_tag falls inside [flush_tag, tail).
    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_mask
            logic [ROB_WIDTH-1:0] offset;
            assign offset          = ROB_WIDTH'(gi) - flush_tag;
            assign squash_mask[gi] = squash_en && (offset < squash_span);
        end
    endgenerate

    always_comb begin
        head_next  = head_reg + ROB_WIDTH'(commit_valid);
        tail_next  = tail_reg + ROB_WIDTH'(alloc_accept);
        count_next = count_reg + (ROB_WIDTH+1)'(alloc_accept) - (ROB_WIDTH+1)'(commit_valid);
        if (squash_en) begin
            tail_next  = flush_tag;
            count_next = {1'b0, flush_tag - head_reg} - (ROB_WIDTH+1)'(commit_valid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch fills at tail, writeback completes, head retires.
// Define ROB_COMMIT_BYPASS_EN to let a writeback to the head retire in the same cycle.
module reorder_buffer
    import rob_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alloc_req,
    input  logic [ROB_WIDTH-1:0]  alloc_tag,
    input  logic                  alloc_has_dest,
    input  logic [AREG_WIDTH-1:0] alloc_areg,
    input  logic [PREG_WIDTH-1:0] alloc_pd_new,
    input  logic [PREG_WIDTH-1:0] alloc_pd_old,
    input  logic                  wb_valid,
    input  logic [ROB_WIDTH-1:0]  wb_tag,
    input  logic                  branch_mispredict,
    input  logic [ROB_WIDTH-1:0]  flush_tag,
    output logic                  rob_full,
    output logic                  rob_empty,
    output logic                  commit_valid,
    output logic [ROB_WIDTH-1:0]  commit_tag,
    output logic                  commit_has_dest,
    output logic [AREG_WIDTH-1:0] commit_areg,
    output logic [PREG_WIDTH-1:0] commit_pd_new,
    output logic [PREG_WIDTH-1:0] commit_pd_old
);
    rob_entry_t           entry_reg [ROB_DEPTH];
    rob_entry_t           head_entry;
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic                 alloc_accept;
    logic [ROB_DEPTH-1:0] squash_mask;
    logic                 wb_hit;

    rob_ptr_ctrl u_ptr_ctrl (
        .clk               (clk),
        .reset_n           (reset_n),
        .alloc_req         (alloc_req),
        .commit_valid      (commit_valid),
        .branch_mispredict (branch_mispredict),
        .flush_tag         (flush_tag),
        .head              (head),
        .tail              (tail),
        .alloc_accept      (alloc_accept),
        .rob_full          (rob_full),
        .rob_empty         (rob_empty),
        .squash_mask       (squash_mask)
    );

    assign head_entry = entry_reg[head];
    // Writebacks to dead entries, or to entries being squashed this cycle, are dropped.
    assign wb_hit     = wb_valid && entry_reg[wb_tag].valid && !squash_mask[wb_tag];

`ifdef ROB_COMMIT_BYPASS_EN
    assign commit_valid = head_entry.valid &&
                          (head_entry.complete || (wb_valid && (wb_tag == head)));
`else
    assign commit_valid = head_entry.valid && head_entry.complete;
`endif

    assign commit_tag      = head;
    assign commit_has_dest = head_entry.has_dest;
    assign commit_areg     = head_entry.areg;
    assign commit_pd_new   = head_entry.pd_new;
    assign commit_pd_old   = head_entry.pd_old;

    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg[gi] <= '0;
                end else if (squash_mask[gi]) begin
                    entry_reg[gi].valid    <= 1'b0;
                    entry_reg[gi].complete <= 1'b0;
                end else if (alloc_accept && (tail == ROB_WIDTH'(gi))) begin
                    entry_reg[gi] <= '{valid: 1'b1, complete: 1'b0, has_dest: alloc_has_dest,
                                       areg: alloc_areg, pd_new: alloc_pd_new,
                                       pd_old: alloc_pd_old};
                end else if (commit_valid && (head == ROB_WIDTH'(gi))) begin
                    entry_reg[gi].valid    <= 1'b0;
                    entry_reg[gi].complete <= 1'b0;
                end else if (wb_hit && (wb_tag == ROB_WIDTH'(gi))) begin
                    entry_reg[gi].complete <= 1'b1;
                end
            end
        end
    endgenerate

    // The allocator's tag is advisory; tail is the authoritative write pointer.
    alloc_tag_matches_tail: assert property (@(posedge clk) disable iff (!reset_n)
        (alloc_req && !rob_full && !branch_mispredict) |-> (alloc_tag == tail));
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a tag-state model of the retirement window.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  alloc_req;
    logic [ROB_WIDTH-1:0]  alloc_tag;
    logic                  alloc_has_dest;
    logic [AREG_WIDTH-1:0] alloc_areg;
    logic [PREG_WIDTH-1:0] alloc_pd_new;
    logic [PREG_WIDTH-1:0] alloc_pd_old;
    logic                  wb_valid;
    logic [ROB_WIDTH-1:0]  wb_tag;
    logic                  branch_mispredict;
    logic [ROB_WIDTH-1:0]  flush_tag;
    logic                  rob_full;
    logic                  rob_empty;
    logic                  commit_valid;
    logic [ROB_WIDTH-1:0]  commit_tag;
    logic                  commit_has_dest;
    logic [AREG_WIDTH-1:0] commit_areg;
    logic [PREG_WIDTH-1:0] commit_pd_new;
    logic [PREG_WIDTH-1:0] commit_pd_old;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .alloc_req         (alloc_req),
        .alloc_tag         (alloc_tag),
        .alloc_has_dest    (alloc_has_dest),
        .alloc_areg        (alloc_areg),
        .alloc_pd_new      (alloc_pd_new),
        .alloc_pd_old      (alloc_pd_old),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .branch_mispredict (branch_mispredict),
        .flush_tag         (flush_tag),
        .rob_full          (rob_full),
        .rob_empty         (rob_empty),
        .commit_valid      (commit_valid),
        .commit_tag        (commit_tag),
        .commit_has_dest   (commit_has_dest),
        .commit_areg       (commit_areg),
        .commit_pd_new     (commit_pd_new),
        .commit_pd_old     (commit_pd_old)
    );

    int n_cmp = 0;
    int n_err = 0;
    int seq   = 0;

    // Model: per-tag state 0=free, 1=waiting for writeback, 2=done; head/tail/occupancy.
    int                    m_state  [32];
    logic                  m_has    [32];
    logic [AREG_WIDTH-1:0] m_areg   [32];
    logic [PREG_WIDTH-1:0] m_pdn    [32];
    logic [PREG_WIDTH-1:0] m_pdo    [32];
    int                    m_head, m_tail, m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_state[k] = 0;
            m_has[k]   = 1'b0;
            m_areg[k]  = '0;
            m_pdn[k]   = '0;
            m_pdo[k]   = '0;
        end
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
    endtask

    function automatic bit exp_commit();
        bit c;
        c = (m_state[m_head] == 2);
`ifdef ROB_COMMIT_BYPASS_EN
        if (m_state[m_head] == 1 && wb_valid && int'(wb_tag) == m_head) c = 1'b1;
`endif
        return c;
    endfunction

    task automatic compare_all();
        chk("rob_full",        32'(rob_full),        32'(m_count == 32));
        chk("rob_empty",       32'(rob_empty),       32'(m_count == 0));
        chk("commit_valid",    32'(commit_valid),    32'(exp_commit()));
        chk("commit_tag",      32'(commit_tag),      32'(m_head));
        chk("commit_has_dest", 32'(commit_has_dest), 32'(m_has[m_head]));
        chk("commit_areg",     32'(commit_areg),     32'(m_areg[m_head]));
        chk("commit_pd_new",   32'(commit_pd_new),   32'(m_pdn[m_head]));
        chk("commit_pd_old",   32'(commit_pd_old),   32'(m_pdo[m_head]));
    endtask

    task automatic model_update();
        bit cv, sq, acc;
        int span, ft, wt, oh;
        cv   = exp_commit();
        ft   = int'(flush_tag);
        wt   = int'(wb_tag);
        oh   = m_head;
        sq   = branch_mispredict && (ft != m_tail);
        span = (m_tail - ft) & 31;
        acc  = alloc_req && (m_count != 32) && !branch_mispredict;
        if (wb_valid && m_state[wt] != 0 && !(sq && (((wt - ft) & 31) < span)))
            m_state[wt] = 2;
        if (cv) begin
            m_state[m_head] = 0;
            m_head = (m_head + 1) % 32;
        end
        if (sq) begin
            for (int k = 0; k < span; k++) m_state[(ft + k) % 32] = 0;
            m_tail  = ft;
            m_count = ((ft - oh) & 31) - int'(cv);
        end else begin
            if (acc) begin
                m_state[m_tail] = 1;
                m_has[m_tail]   = alloc_has_dest;
                m_areg[m_tail]  = alloc_areg;
                m_pdn[m_tail]   = alloc_pd_new;
                m_pdo[m_tail]   = alloc_pd_old;
                m_tail = (m_tail + 1) % 32;
            end
            m_count = m_count + int'(acc) - int'(cv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic set_idle();
        alloc_req = 0; alloc_tag = '0; alloc_has_dest = 0; alloc_areg = '0;
        alloc_pd_new = '0; alloc_pd_old = '0; wb_valid = 0; wb_tag = '0;
        branch_mispredict = 0; flush_tag = '0;
    endtask

    task automatic set_alloc();
        alloc_req      = 1;
        alloc_tag      = ROB_WIDTH'(m_tail);
        alloc_has_dest = seq[0];
        alloc_areg     = AREG_WIDTH'(seq * 3 + 1);
        alloc_pd_new   = PREG_WIDTH'(seq + 5);
        alloc_pd_old   = PREG_WIDTH'(seq * 7 + 2);
        seq++;
    endtask

    task automatic set_wb(input int t);
        wb_valid = 1;
        wb_tag   = ROB_WIDTH'(t);
    endtask

    task automatic alloc_one();
        set_alloc(); tick(); set_idle();
    endtask

    task automatic wb_one(input int t);
        set_wb(t); tick(); set_idle();
    endtask

    task automatic do_reset();
        reset_n = 0; model_reset(); tick(); reset_n = 1; tick();
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 64 && !rob_empty; i++) tick();
        chk(nm, 32'(rob_empty), 32'd1);
    endtask

    initial begin
        set_idle();
        reset_n = 0;
        model_reset();
        tick(); tick();
        chk("reset_empty",  32'(rob_empty),    32'd1);
        chk("reset_full",   32'(rob_full),     32'd0);
        chk("reset_commit", 32'(commit_valid), 32'd0);
        chk("reset_pd_old", 32'(commit_pd_old), 32'd0);
        reset_n = 1;
        tick();

        // 1: reset while five entries are live, one of them complete
        for (int i = 0; i < 5; i++) alloc_one();
        wb_one(1);
        reset_n = 0;
        model_reset();
        #1;
        chk("t1_empty_now",  32'(rob_empty),    32'd1);
        chk("t1_commit_now", 32'(commit_valid), 32'd0);
        tick();
        reset_n = 1;
        repeat (3) tick();
        chk("t1_no_commit", 32'(commit_valid), 32'd0);

        // 2: fill all 32 tags, then an extra request must be ignored
        for (int i = 0; i < 32; i++) alloc_one();
        chk("t2_full", 32'(rob_full), 32'd1);
        set_alloc(); tick(); set_idle();
        chk("t2_still_full", 32'(rob_full), 32'd1);
        chk("t2_model_tail", 32'(m_tail), 32'd0);

        // 5: full buffer, head retires while dispatch tries to allocate
`ifndef ROB_COMMIT_BYPASS_EN
        wb_one(0);
`endif
        set_alloc();
`ifdef ROB_COMMIT_BYPASS_EN
        set_wb(0);
`endif
        #1;
        chk("t5_commit",    32'(commit_valid), 32'd1);
        chk("t5_full_then", 32'(rob_full),     32'd1);
        tick(); set_idle();
        chk("t5_not_full",  32'(rob_full),  32'd0);
        chk("t5_not_empty", 32'(rob_empty), 32'd0);
        alloc_one();
        chk("t5_full_again", 32'(rob_full), 32'd1);
        for (int k = 1; k <= 32; k++) wb_one(k % 32);
        drain("t5_drain");

        // 3: out-of-order writeback, in-order retirement
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one();
        wb_one(2);
        wb_one(0);
`ifndef ROB_COMMIT_BYPASS_EN
        chk("t3_commit0_valid", 32'(commit_valid), 32'd1);
        chk("t3_commit0_tag",   32'(commit_tag),   32'd0);
        tick();
`endif
        chk("t3_blocked_valid", 32'(commit_valid), 32'd0);
        chk("t3_blocked_tag",   32'(commit_tag),   32'd1);
        wb_one(1);
`ifndef ROB_COMMIT_BYPASS_EN
        chk("t3_commit1_valid", 32'(commit_valid), 32'd1);
        chk("t3_commit1_tag",   32'(commit_tag),   32'd1);
        tick();
`endif
        chk("t3_commit2_valid", 32'(commit_valid), 32'd1);
        chk("t3_commit2_tag",   32'(commit_tag),   32'd2);
        tick();
        chk("t3_wait3_valid", 32'(commit_valid), 32'd0);
        chk("t3_wait3_tag",   32'(commit_tag),   32'd3);
        wb_one(3);
        drain("t3_drain");

        // 4: mispredict squashes the wrapped-around younger tags
        do_reset();
        for (int i = 0; i < 30; i++) begin
            set_alloc();
            if (i > 0) set_wb(i - 1);
            tick(); set_idle();
        end
        wb_one(29);
        drain("t4_pre_drain");
        chk("t4_head30", 32'(commit_tag), 32'd30);
        for (int i = 0; i < 4; i++) alloc_one();
        set_alloc();
        branch_mispredict = 1;
        flush_tag = 5'd0;
        set_wb(1);
        tick(); set_idle();
        chk("t4_model_tail",  32'(m_tail),  32'd0);
        chk("t4_model_count", 32'(m_count), 32'd2);
        chk("t4_not_empty", 32'(rob_empty), 32'd0);
        wb_one(30);
        wb_one(31);
        repeat (2) tick();
        chk("t4_empty_after_two", 32'(rob_empty), 32'd1);
        chk("t4_head0",           32'(commit_tag), 32'd0);

        // 6: writeback-to-commit latency at the head
        alloc_one();
        set_wb(0);
        #1;
`ifdef ROB_COMMIT_BYPASS_EN
        chk("t6_same_cycle", 32'(commit_valid), 32'd1);
`else
        chk("t6_same_cycle", 32'(commit_valid), 32'd0);
`endif
        tick(); set_idle();
`ifndef ROB_COMMIT_BYPASS_EN
        chk("t6_next_cycle", 32'(commit_valid), 32'd1);
        tick();
`endif
        chk("t6_empty", 32'(rob_empty), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
